// File: rtl/acc8_seq_if.sv
// -----------------------------------------------------------------------------
// acc8_seq_if
// Purpose : Bundles every non-clock signal of the acc8_seq accumulator
//           controller. The bundle covers the request handshake, the result
//           handshake and the link to the external combinational adder.
// Parameter:
//   WIDTH      datapath width. It must match the attached adder.
// Signals:
//   in_valid   request valid              (requester -> controller)
//   in_ready   controller can accept      (controller -> requester)
//   in_op      00 LOAD, 01 ADD, 10 SUB, 11 ADC
//   in_data    operand
//   out_valid  result available           (controller -> consumer)
//   out_ready  consumer accepts result    (consumer -> controller)
//   out_acc    accumulator register
//   out_flags  {V,N,Z,C} flag register
//   add_a/b    adder operand inputs       (controller -> adder)
//   add_cin    adder carry-in             (controller -> adder)
//   add_sum    adder sum                  (adder -> controller)
//   add_cout   adder carry-out            (adder -> controller)
// Modports:
//   master : the environment around the controller. This side holds the
//            requester, the consumer and the adder.
//   slave  : the acc8_seq controller itself.
// -----------------------------------------------------------------------------
interface acc8_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_acc;
    logic [3:0]       out_flags;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    modport master (
        output in_valid,
        output in_op,
        output in_data,
        output out_ready,
        output add_sum,
        output add_cout,
        input  in_ready,
        input  out_valid,
        input  out_acc,
        input  out_flags,
        input  add_a,
        input  add_b,
        input  add_cin
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_data,
        input  out_ready,
        input  add_sum,
        input  add_cout,
        output in_ready,
        output out_valid,
        output out_acc,
        output out_flags,
        output add_a,
        output add_b,
        output add_cin
    );
endinterface

// File: rtl/acc8_seq.sv
// -----------------------------------------------------------------------------
// acc8_seq
// Purpose : Sequenced accumulator controller wrapped around an external,
//           purely combinational ripple adder.
//           - It accepts one operation (LOAD/ADD/SUB/ADC) and its operand
//             through a valid/ready handshake.
//           - During the EXEC cycle it drives the adder from the accumulator
//             and the operand.
//           - At the end of EXEC it captures Sum/Cout into the accumulator
//             and the {V,N,Z,C} flag register.
//           - It holds the result in DONE until downstream accepts it.
//           Throughput is one operation every three cycles:
//           IDLE -> EXEC -> DONE.
// Ports   :
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   bus        acc8_seq_if.slave. This carries the request handshake
//              (in_*), the result handshake (out_*) and the adder link (add_*).
// Parameter:
//   WIDTH      datapath width. It must equal the width of the attached adder.
// Build option:
//   ACC8_SAT_EN  When defined, a signed overflow on ADD/SUB/ADC clamps the
//                accumulator to the signed max or min value. When it is not
//                defined, the result wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module acc8_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    acc8_seq_if.slave  bus
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_ADC  = 2'b11;

    // Flag register bit positions: {V,N,Z,C}
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Registered state
    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_q;
    logic [3:0]       flags_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // Adder drive
    logic [WIDTH-1:0] add_a_c;
    logic [WIDTH-1:0] add_b_c;
    logic             add_cin_c;

    // Values captured at the end of EXEC
    logic             is_load;
    logic             c_d;
    logic             v_d;
    logic [WIDTH-1:0] acc_d;
    logic [3:0]       flags_d;

`ifdef ACC8_SAT_EN
    // On signed overflow, clamp toward the sign of the accumulator operand.
    // Overflow can only occur when both adder operands share a sign, so the
    // sign of add_a gives the direction of the overflow.
    function automatic logic signed [WIDTH-1:0] sat_result(
        input logic [WIDTH-1:0] sum,
        input logic             ovf,
        input logic             a_neg
    );
        logic signed [WIDTH-1:0] res;
        if (!ovf)
            res = $signed(sum);
        else if (a_neg)
            res = $signed({1'b1, {MSB{1'b0}}});
        else
            res = $signed({1'b0, {MSB{1'b1}}});
        return res;
    endfunction
`endif

    // ---- Adder input steering ----------------------------------------------
    // The adder is idle (all zero) outside EXEC. SUB uses a + ~b + 1.
    always_comb begin
        add_a_c   = '0;
        add_b_c   = '0;
        add_cin_c = 1'b0;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_LOAD: begin
                    add_b_c   = opnd_q;
                end
                OP_ADD: begin
                    add_a_c   = acc_q;
                    add_b_c   = opnd_q;
                end
                OP_SUB: begin
                    add_a_c   = acc_q;
                    add_b_c   = ~opnd_q;
                    add_cin_c = 1'b1;
                end
                OP_ADC: begin
                    add_a_c   = acc_q;
                    add_b_c   = opnd_q;
                    add_cin_c = flags_q[FLAG_C];
                end
            endcase
        end
    end

    // ---- Result and flag formation (meaningful only in EXEC) ---------------
    always_comb begin
        is_load = (op_q == OP_LOAD);
        // A LOAD passes the operand through the adder. It must not report
        // carry or overflow.
        c_d = ~is_load & bus.add_cout;
        v_d = ~is_load
            & (add_a_c[MSB] == add_b_c[MSB])
            & (bus.add_sum[MSB] != add_a_c[MSB]);
`ifdef ACC8_SAT_EN
        acc_d = sat_result(bus.add_sum, v_d, add_a_c[MSB]);
`else
        acc_d = bus.add_sum;
`endif
        // N and Z come from the value actually stored. This matters when
        // the stored value is a saturated one.
        flags_d = {v_d, acc_d[MSB], (acc_d == '0), c_d};
    end

    // ---- Control FSM with registered handshake outputs ---------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOAD;
            opnd_q      <= '0;
            acc_q       <= '0;
            flags_q     <= 4'b0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.in_op;
                        opnd_q     <= bus.in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc_q       <= acc_d;
                    flags_q     <= flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    // in_valid is deliberately ignored until the result
                    // has been taken.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // ---- Output drive ------------------------------------------------------
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_flags = flags_q;
    assign bus.add_a     = add_a_c;
    assign bus.add_b     = add_b_c;
    assign bus.add_cin   = add_cin_c;

endmodule

// File: doc/acc8_seq.md
Name: acc8_seq

Overview:
- Sequenced accumulator controller that sits directly around the 8-bit ripple adder.
- Latches an operation and operand through a valid/ready handshake, then drives the adder's A/B/Cin inputs from its accumulator and the operand.
- Captures the adder's Sum/Cout back into the accumulator and flag register.
- Presents the result downstream through a valid/ready handshake; the adder itself stays external and purely combinational.

Parameters:
- WIDTH, 8, datapath width; must equal the width of the attached adder.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- in_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 ADC.
- in_data  input  WIDTH  operand.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  WIDTH  accumulator register, continuously driven.
- out_flags  output  4  {V,N,Z,C} flag register, continuously driven.
- add_a  output  WIDTH  to adder A.
- add_b  output  WIDTH  to adder B.
- add_cin  output  1  to adder Cin.
- add_sum  input  WIDTH  from adder Sum.
- add_cout  input  1  from adder Cout.

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst).
- Reset: state IDLE, acc=0, flags=0000, out_valid=0, in_ready=1, op/operand registers=0. Reset asserted mid-operation aborts the operation immediately, with no partial update.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 at an edge latches in_op and in_data, then moves to EXEC.
- EXEC:
  - in_ready=0.
  - Adder inputs are driven combinationally from registered values:
    - ADD: add_a=acc, add_b=operand, add_cin=0.
    - SUB: add_a=acc, add_b=~operand, add_cin=1.
    - ADC: add_a=acc, add_b=operand, add_cin=C flag.
    - LOAD: add_a=0, add_b=operand, add_cin=0.
  - At the closing edge, acc<=add_sum and flags update; state moves to DONE.
- DONE:
  - out_valid=1; out_acc and out_flags are stable.
  - out_ready=1 at an edge moves to IDLE.
  - out_ready=0 holds DONE indefinitely.
  - in_valid is ignored and in_ready=0.
- Adder inputs in IDLE and DONE: add_a=0, add_b=0, add_cin=0.
- Latency and throughput:
  - Request accepted at edge k gives out_valid high after edge k+1.
  - Earliest next acceptance is edge k+3, so throughput is one operation per 3 cycles.
- Flags, computed from the EXEC adder inputs and outputs:
  - C=add_cout. For SUB, C=1 means no borrow. LOAD forces C=0.
  - V = (add_a[MSB]==add_b[MSB]) & (add_sum[MSB]!=add_a[MSB]). LOAD forces V=0.
  - Z = (new acc==0).
  - N = new acc[MSB].
- Arithmetic is modulo 2^WIDTH; wrap-around is unsignalled except through C and V.
- The add_sum/add_cout inputs are sampled only at the EXEC closing edge; values in other states are don't-care.

Optional Feature:
- Macro: ACC8_SAT_EN.
- Defined:
  - For ADD/SUB/ADC with V=1, acc saturates to signed max 0x7F…F if add_a[MSB]==0, else signed min 0x80…0.
  - V stays 1; C follows add_cout.
  - Z and N are recomputed from the saturated value.
- Undefined: acc always takes add_sum (wrapping). No extra logic is synthesised.

Test Plan:
- LOAD 0x05, then ADD 0x03 -> out_acc=0x08, flags=0000; out_valid rises one cycle after the EXEC cycle.
- LOAD 0xFF, then ADD 0x01 -> out_acc=0x00, flags V0 N0 Z1 C1.
- LOAD 0x7F, then ADD 0x01:
  - Without ACC8_SAT_EN -> 0x80, flags V1 N1 Z0 C0.
  - With ACC8_SAT_EN -> 0x7F, flags V1 N0 Z0 C0.
- LOAD 0x03, SUB 0x05 -> 0xFE, flags V0 N1 Z0 C0; then ADC 0x01 (C=0) -> 0xFF, add_cin observed 0 in EXEC.
- Backpressure: hold out_ready=0 for 5 cycles after result with in_valid=1 -> out_valid stays 1, out_acc/out_flags stable, in_ready=0, no request latched; release -> IDLE next cycle.
- Assert rst asynchronously in EXEC after LOAD 0x05 / ADD 0x03 -> out_acc=0, flags=0, out_valid=0, in_ready=1 without waiting for a clock edge; the next ADD 0x02 yields 0x02.
